// File: rtl/hex_display_ctrl_if.sv
// Bus bundle for hex_display_ctrl: control strobes and display data in,
// segment fields and held value out.
//
// Handshake: there is no valid/ready pair. load and inc are single-cycle
// strobes sampled on every rising clock edge and always accepted, and
// load wins over inc. blank_lz and blink_en are level controls. segs, held
// and wrap are registered and valid on every cycle outside reset.
interface hex_display_ctrl_if #(
    parameter int DIGITS = 6
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic                  inc;
    logic                  blank_lz;
    logic [DIGITS-1:0]     blink_en;
    logic [7*DIGITS-1:0]   segs;
    logic [4*DIGITS-1:0]   held;
    logic                  wrap;

    modport master (
        output load, value, inc, blank_lz, blink_en,
        input  segs, held, wrap
    );

    modport slave (
        input  load, value, inc, blank_lz, blink_en,
        output segs, held, wrap
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex seven-segment controller: a loadable/incrementable held
// value, registered active-low glyph fields, leading-zero blanking and a
// per-digit blink driven by a free-running prescaler.
module hex_display_ctrl #(
    parameter int DIGITS    = 6,
    parameter int BLINK_DIV = 25000000
) (
    input  logic               clock,
    input  logic               reset,
    hex_display_ctrl_if.slave  bus
);
    localparam int HW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
    localparam logic [6:0]    SEG_BLANK = 7'h7F;

    logic [HW-1:0] held_q, held_d;
    logic          wrap_q, wrap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic [SW-1:0] segs_q, segs_d;

    // Scratch values for the per-digit render loop.
    logic [3:0]    nib;
    logic          nz_above;
    logic          dig_blank;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Held register update: load beats inc; wrap flags an all-F rollover.
    always_comb begin
        held_d = held_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            held_d = bus.value;
        end else if (bus.inc) begin
            held_d = held_q + HW'(1);
            wrap_d = (held_q == '1);
        end
    end

    // Free-running blink prescaler; phase flips each time cnt wraps.
    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // Render every digit from the current held value and phase. Walking from
    // the top digit down, nz_above tracks whether any nonzero nibble has been
    // seen, which is exactly the leading-zero condition.
    always_comb begin
        segs_d    = '1;
        nib       = '0;
        nz_above  = 1'b0;
        dig_blank = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib       = held_q[4*i +: 4];
            nz_above  = nz_above | (nib != 4'h0);
            dig_blank = (bus.blank_lz && (i != 0) && !nz_above) ||
                        (phase_q && bus.blink_en[i]);
            segs_d[7*i +: 7] = dig_blank ? SEG_BLANK : glyph(nib);
        end
    end

    // State registers; reset blanks the display and drops any pending wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held_q  <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            segs_q  <= '1;
        end else begin
            held_q  <= held_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            segs_q  <= segs_d;
        end
    end

    assign bus.segs = segs_q;
    assign bus.held = held_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl (6 digits, short blink period). The driver
// pushes expected outputs per clock edge; the monitor pops and compares.
module tb_hex_display_ctrl;
  localparam int DIGITS    = 6;
  localparam int BLINK_DIV = 4;
  localparam int HW        = 4 * DIGITS;
  localparam int SW        = 7 * DIGITS;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic probe = 1'b0;
  always #5 clock = ~clock;

  hex_display_ctrl_if #(.DIGITS(DIGITS)) bus ();

  hex_display_ctrl #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- reference model ----------------
  logic [6:0] glyph_tab [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [HW-1:0] held_m;
  int            edges_m;

  function automatic logic [SW-1:0] render(input logic [HW-1:0] h, input bit ph,
                                           input bit blz, input logic [DIGITS-1:0] ben);
    logic [SW-1:0] r;
    logic [HW-1:0] upper;
    bit            blank;
    r = '1;
    for (int i = 0; i < DIGITS; i++) begin
      upper = h >> (4 * i);
      blank = (blz && i > 0 && upper == 0) || (ph && ben[i]);
      r[7*i +: 7] = blank ? 7'h7F : glyph_tab[int'(upper & 'hF)];
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [SW-1:0] exp_segs_q[$];
  logic [HW-1:0] exp_held_q[$];
  logic [0:0]    exp_wrap_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic push_exp(input logic [SW-1:0] s, input logic [HW-1:0] h, input logic w);
    exp_segs_q.push_back(s);
    exp_held_q.push_back(h);
    exp_wrap_q.push_back(w);
  endtask

  // Monitor: samples 1 time unit after each rising edge or reset probe.
  initial begin : monitor
    logic [SW-1:0] es;
    logic [HW-1:0] eh;
    logic [0:0]    ew;
    forever begin
      @(posedge clock or posedge probe);
      #1;
      if (exp_segs_q.size() > 0) begin
        es = exp_segs_q.pop_front();
        eh = exp_held_q.pop_front();
        ew = exp_wrap_q.pop_front();
        n_tests++;
        if (bus.segs !== es) begin
          n_fail++;
          $display("FAIL segs @%0t: got %h expected %h", $time, bus.segs, es);
        end
        n_tests++;
        if (bus.held !== eh) begin
          n_fail++;
          $display("FAIL held @%0t: got %h expected %h", $time, bus.held, eh);
        end
        n_tests++;
        if (bus.wrap !== ew) begin
          n_fail++;
          $display("FAIL wrap @%0t: got %b expected %b", $time, bus.wrap, ew);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle of stimulus; expectation is for the state after the next edge.
  task automatic cycle(input logic ld, input logic [HW-1:0] val, input logic in,
                       input logic blz, input logic [DIGITS-1:0] ben);
    logic [SW-1:0] s_e;
    logic          w_e;
    @(negedge clock);
    bus.load     = ld;
    bus.value    = val;
    bus.inc      = in;
    bus.blank_lz = blz;
    bus.blink_en = ben;
    s_e = render(held_m, ((edges_m / BLINK_DIV) % 2) == 1, blz, ben);
    w_e = in && !ld && (held_m == {HW{1'b1}});
    if (ld)      held_m = val;
    else if (in) held_m = held_m + 1;
    edges_m++;
    push_exp(s_e, held_m, w_e);
  endtask

  // Assert reset dly units after a falling edge, check it took effect at
  // once, then release it between edges.
  task automatic async_reset(input int dly);
    @(negedge clock);
    #dly;
    bus.load = 1'b0;
    bus.inc  = 1'b0;
    reset    = 1'b1;
    held_m   = '0;
    edges_m  = 0;
    push_exp({SW{1'b1}}, '0, 1'b0);
    probe = 1'b1;
    #2;
    probe = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [HW-1:0] rv;
    logic          rl, ri, rb;
    logic [DIGITS-1:0] re;
    bus.load = 1'b0; bus.value = '0; bus.inc = 1'b0;
    bus.blank_lz = 1'b0; bus.blink_en = '0;
    held_m = '0; edges_m = 0;

    async_reset(0);
    cycle(0, '0, 0, 0, '0);                 // held=0 shown on all digits

    // Load 00C0DE, no blanking
    cycle(1, 24'h00C0DE, 0, 0, '0);
    cycle(0, '0, 0, 0, '0);
    cycle(0, '0, 0, 0, '0);

    // Leading-zero blanking, then value 0 shows a single digit
    cycle(1, 24'h000A05, 0, 1, '0);
    cycle(0, '0, 0, 1, '0);
    cycle(1, 24'h000000, 0, 1, '0);
    cycle(0, '0, 0, 1, '0);
    cycle(1, 24'h100000, 0, 1, '0);
    cycle(0, '0, 0, 1, '0);

    // Rollover and wrap pulse, then load+inc together
    cycle(1, 24'hFFFFFE, 0, 0, '0);
    cycle(0, '0, 1, 0, '0);
    cycle(0, '0, 1, 0, '0);
    cycle(0, '0, 0, 0, '0);
    cycle(0, '0, 0, 0, '0);
    cycle(1, 24'hFFFFFF, 0, 0, '0);
    cycle(1, 24'h00ABCD, 1, 0, '0);
    cycle(0, '0, 0, 0, '0);

    // Blink on digit 0
    cycle(1, 24'h000003, 0, 0, 6'b000001);
    for (int i = 0; i < 20; i++) cycle(0, '0, 0, 0, 6'b000001);

    // Asynchronous reset mid-cycle with a nonzero held value
    cycle(1, 24'h123456, 0, 0, '0);
    cycle(0, '0, 0, 0, '0);
    async_reset(2);
    cycle(0, '0, 0, 0, '0);
    cycle(0, '0, 0, 0, '0);

    // Pending wrap pulse cleared by reset
    cycle(1, 24'hFFFFFF, 0, 0, '0);
    cycle(0, '0, 1, 0, '0);
    async_reset(3);
    cycle(0, '0, 0, 0, '0);

    // Sweep digit 0 through all sixteen glyphs
    cycle(1, 24'h000000, 0, 0, '0);
    for (int i = 0; i < 16; i++) cycle(0, '0, 1, 0, '0);
    cycle(0, '0, 0, 0, '0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rl = ($urandom_range(0, 7) == 0);
      ri = ($urandom_range(0, 2) != 0);
      rb = 1'($urandom_range(0, 1));
      re = DIGITS'($urandom);
      case ($urandom_range(0, 3))
        0:       rv = HW'($urandom);
        1:       rv = HW'($urandom_range(0, 255));
        2:       rv = {HW{1'b1}} - HW'($urandom_range(0, 3));
        default: rv = HW'($urandom_range(0, 15)) << (4 * $urandom_range(0, DIGITS - 1));
      endcase
      cycle(rl, rv, ri, rb, re);
    end

    @(negedge clock);
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
